// File: rtl/rv_dbg_pkg.sv
// Shared definitions for the UART-driven Wishbone debug initiator:
// FSM states plus the command and response byte codes.
package rv_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_BUS,
        ST_RESP
    } dbg_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;
    localparam logic [7:0] RSP_BAD   = 8'h3F;

endpackage

// File: rtl/wb_dbg_timeout.sv
// Bus-cycle watchdog: counts cycles while enabled and flags the last
// cycle of the allowed window so the initiator can abandon the access.
module wb_dbg_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= count + 16'd1;
        end
    end

    // Asserted during the final permitted cycle so the exit edge closes the window exactly.
    assign o_expired = i_enable && (count == LIMIT);

endmodule

// File: rtl/wb_dbg_master.sv
// Debug bridge: parses W/R frames from a UART byte stream, runs one
// Wishbone classic cycle per frame and streams back a status/data response.
module wb_dbg_master
    import rv_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_stb,
    input  logic        i_wb_ack,
    output logic        o_wb_cyc
);

    dbg_state_t  state, next_state;
    logic        alive;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_wr;
    logic        rd_ok;
    logic        resp_phase;
    logic [7:0]  tx_data;
    logic        tx_valid;

    logic        rx_fire;
    logic        tx_fire;
    logic        cmd_ok;
    logic        last_byte;
    logic        expired;
    logic        to_clear;
    logic        to_enable;

    assign cnt_nxt    = cnt + 2'd1;
    assign o_rx_ready = alive && ((state == ST_IDLE) || (state == ST_ADDR) || (state == ST_WDATA));
    assign rx_fire    = i_rx_valid && o_rx_ready;
    assign tx_fire    = tx_valid && i_tx_ready;
    assign cmd_ok     = (i_rx_data == CMD_WRITE) || (i_rx_data == CMD_READ);
    assign last_byte  = !rd_ok || (resp_phase && (cnt == 2'd3));

    assign o_tx_data  = tx_data;
    assign o_tx_valid = tx_valid;
    assign o_wb_adr   = addr & 32'hFFFF_FFFC;
    assign o_wb_dat   = data;

    assign to_clear   = (next_state == ST_BUS) && (state != ST_BUS);
    assign to_enable  = (state == ST_BUS);

    wb_dbg_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_clear  (to_clear),
        .i_enable (to_enable),
        .o_expired(expired)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_sel   = '0;
        o_wb_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_fire) next_state = cmd_ok ? ST_ADDR : ST_RESP;
            end
            ST_ADDR: begin
                if (rx_fire && (cnt == 2'd3)) next_state = is_wr ? ST_WDATA : ST_BUS;
            end
            ST_WDATA: begin
                if (rx_fire && (cnt == 2'd3)) next_state = ST_BUS;
            end
            ST_BUS: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                o_wb_sel = '1;
                o_wb_we  = is_wr;
                if (i_wb_ack || expired) next_state = ST_RESP;
            end
            ST_RESP: begin
                if (tx_fire && last_byte) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            alive      <= 1'b0;
            cnt        <= '0;
            addr       <= '0;
            data       <= '0;
            is_wr      <= 1'b0;
            rd_ok      <= 1'b0;
            resp_phase <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
        end else begin
            alive <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        cnt   <= '0;
                        is_wr <= (i_rx_data == CMD_WRITE);
                        if (!cmd_ok) begin
                            tx_data    <= RSP_BAD;
                            tx_valid   <= 1'b1;
                            rd_ok      <= 1'b0;
                            resp_phase <= 1'b0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        addr[{cnt, 3'b000} +: 8] <= i_rx_data;
                        cnt                      <= cnt_nxt;
                    end
                end
                ST_WDATA: begin
                    if (rx_fire) begin
                        data[{cnt, 3'b000} +: 8] <= i_rx_data;
                        cnt                      <= cnt_nxt;
                    end
                end
                ST_BUS: begin
                    // Ack wins over a simultaneous expiry: the slave answered inside the window.
                    if (i_wb_ack) begin
                        tx_data    <= RSP_ACK;
                        tx_valid   <= 1'b1;
                        rd_ok      <= !is_wr;
                        resp_phase <= 1'b0;
                        cnt        <= '0;
                        if (!is_wr) data <= i_wb_dat;
                    end else if (expired) begin
                        tx_data    <= RSP_NAK;
                        tx_valid   <= 1'b1;
                        rd_ok      <= 1'b0;
                        resp_phase <= 1'b0;
                        cnt        <= '0;
                    end
                end
                ST_RESP: begin
                    if (tx_fire) begin
                        if (last_byte) begin
                            tx_valid <= 1'b0;
                            cnt      <= '0;
                        end else if (!resp_phase) begin
                            resp_phase <= 1'b1;
                            cnt        <= '0;
                            tx_data    <= data[7:0];
                        end else begin
                            cnt     <= cnt_nxt;
                            tx_data <= data[{cnt_nxt, 3'b000} +: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dbg_master.sv
// Self-checking bench for wb_dbg_master: directed scenarios plus random
// frames checked against a word-level memory model of the expected traffic.
module tb_wb_dbg_master;

    localparam int unsigned TO = 16;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat = '0;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic        o_wb_stb;
    logic        i_wb_ack = 1'b0;
    logic        o_wb_cyc;

    int checks = 0;
    int errors = 0;

    wb_dbg_master #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_rx_data (i_rx_data),
        .i_rx_valid(i_rx_valid),
        .o_rx_ready(o_rx_ready),
        .o_tx_data (o_tx_data),
        .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready),
        .o_wb_adr  (o_wb_adr),
        .o_wb_dat  (o_wb_dat),
        .i_wb_dat  (i_wb_dat),
        .o_wb_we   (o_wb_we),
        .o_wb_sel  (o_wb_sel),
        .o_wb_stb  (o_wb_stb),
        .i_wb_ack  (i_wb_ack),
        .o_wb_cyc  (o_wb_cyc)
    );

    always #5 i_clk = ~i_clk;

    // Slave memory, acked transactions and cyc-high lengths observed on the bus.
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } txn_t;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    txn_t        txq [$];
    int unsigned lenq [$];
    int unsigned s_cnt = 0;
    int unsigned cur_len = 0;
    bit          ack_en = 1'b1;
    int unsigned ack_delay = 0;
    bit          stray_ack = 1'b0;

    always @(negedge i_clk) begin
        if (o_wb_cyc && o_wb_stb) begin
            s_cnt   = s_cnt + 1;
            cur_len = cur_len + 1;
            if (ack_en && (s_cnt == ack_delay + 1)) begin
                i_wb_ack = 1'b1;
                txq.push_back('{adr: o_wb_adr, dat: o_wb_dat, we: o_wb_we, sel: o_wb_sel});
                if (o_wb_we) mem[o_wb_adr] = o_wb_dat;
                else i_wb_dat = mem.exists(o_wb_adr) ? mem[o_wb_adr] : 32'h0;
            end else begin
                i_wb_ack = 1'b0;
                i_wb_dat = $urandom;
            end
        end else begin
            if (cur_len != 0) lenq.push_back(cur_len);
            cur_len  = 0;
            s_cnt    = 0;
            i_wb_ack = stray_ack;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_wait: rx_ready=%b required 1 for byte %h", o_rx_ready, b);
        end
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, input bit stall);
        int unsigned n;
        n = 0;
        if (stall) begin
            i_tx_ready = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end
        i_tx_ready = 1'b1;
        while (!o_tx_valid && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL recv_wait: tx_valid=%b required 1", o_tx_valid);
        end
        b = o_tx_data;
        @(negedge i_clk);
    endtask

    // Sends one frame and checks response bytes, bus transaction and cycle length.
    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                             input logic [31:0] wdat, input bit stall);
        logic [7:0]  exp_q [$];
        logic [7:0]  got;
        logic [31:0] word;
        logic [31:0] rd_val;
        bit          valid;
        bit          wr;
        bit          to;
        int unsigned exp_len;
        valid  = (cmd == 8'h57) || (cmd == 8'h52);
        wr     = (cmd == 8'h57);
        to     = !ack_en || (ack_delay + 1 > TO);
        word   = {addr[31:2], 2'b00};
        rd_val = model_mem.exists(word) ? model_mem[word] : 32'h0;
        if (!valid) exp_q.push_back(8'h3F);
        else if (to) exp_q.push_back(8'h15);
        else begin
            exp_q.push_back(8'h06);
            if (!wr) for (int k = 0; k < 4; k++) exp_q.push_back(rd_val[8*k +: 8]);
        end
        exp_len = to ? TO : ack_delay + 1;
        txq.delete();
        lenq.delete();

        send_byte(cmd);
        if (valid) begin
            for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8]);
            if (wr) for (int k = 0; k < 4; k++) send_byte(wdat[8*k +: 8]);
            checks++;
            if (o_wb_cyc !== 1'b1) begin
                errors++;
                $display("FAIL bus_entry: cyc=%b required 1 after last byte", o_wb_cyc);
            end
        end
        foreach (exp_q[i]) begin
            recv_byte(got, stall);
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL resp_byte[%0d] cmd=%h: got %h required %h", i, cmd, got, exp_q[i]);
            end
        end
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_tx_valid !== 1'b0 || o_rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after: tx_valid=%b rx_ready=%b required 0/1", o_tx_valid, o_rx_ready);
        end
        checks++;
        if (txq.size() != ((valid && !to) ? 1 : 0)) begin
            errors++;
            $display("FAIL txn_count: got %0d required %0d", txq.size(), (valid && !to) ? 1 : 0);
        end
        if (valid && !to && txq.size() == 1) begin
            checks++;
            if (txq[0].adr !== word) begin
                errors++;
                $display("FAIL bus_adr: got %h required %h", txq[0].adr, word);
            end
            checks++;
            if (txq[0].we !== wr || txq[0].sel !== 4'hF) begin
                errors++;
                $display("FAIL bus_ctl: we=%b sel=%h required we=%b sel=f", txq[0].we, txq[0].sel, wr);
            end
            if (wr) begin
                checks++;
                if (txq[0].dat !== wdat) begin
                    errors++;
                    $display("FAIL bus_dat: got %h required %h", txq[0].dat, wdat);
                end
            end
        end
        if (valid) begin
            checks++;
            if (lenq.size() != 1 || lenq[0] != exp_len) begin
                errors++;
                $display("FAIL cyc_len: got %0d cycles (%0d cycles seen) required %0d",
                         (lenq.size() > 0) ? lenq[0] : 0, lenq.size(), exp_len);
            end
        end
        if (valid && wr && !to) model_mem[word] = wdat;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_rx_ready !== 1'b0 || o_tx_valid !== 1'b0 || o_tx_data !== 8'h00 ||
            o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_wb_we !== 1'b0 || o_wb_sel !== 4'h0 ||
            o_wb_adr !== 32'h0 || o_wb_dat !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b txv=%b txd=%h cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h required all 0",
                     o_rx_ready, o_tx_valid, o_tx_data, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat);
        end
        i_reset_n = 1'b1;
        #1;
        checks++;
        if (o_rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_rdy: got %b required 0", o_rx_ready);
        end
        @(negedge i_clk);
        checks++;
        if (o_rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_rise_rdy: got %b required 1", o_rx_ready);
        end
    endtask

    task automatic test_write();
        ack_en    = 1'b1;
        ack_delay = 3;
        run_frame(8'h57, 32'h2000_0000, 32'hDEAD_BEEF, 1'b0);
        run_frame(8'h52, 32'h2000_0000, 32'h0, 1'b0);
    endtask

    task automatic test_read();
        ack_delay = 1;
        mem[32'h4]       = 32'h1234_5678;
        model_mem[32'h4] = 32'h1234_5678;
        run_frame(8'h52, 32'h0000_0004, 32'h0, 1'b0);
        ack_delay = 0;
        run_frame(8'h52, 32'h0000_0007, 32'h0, 1'b0);
    endtask

    task automatic test_timeout();
        ack_en = 1'b0;
        run_frame(8'h52, 32'hF000_0000, 32'h0, 1'b0);
        run_frame(8'h57, 32'hF000_0010, 32'h1111_2222, 1'b0);
        ack_en    = 1'b1;
        ack_delay = TO - 1;
        run_frame(8'h52, 32'hF000_0000, 32'h0, 1'b0);
        ack_delay = TO;
        run_frame(8'h52, 32'hF000_0000, 32'h0, 1'b0);
        ack_delay = 2;
    endtask

    task automatic test_bad_cmd();
        run_frame(8'h41, 32'h0, 32'h0, 1'b0);
        run_frame(8'h00, 32'h0, 32'h0, 1'b0);
        run_frame(8'h52, 32'h0000_0004, 32'h0, 1'b0);
    endtask

    task automatic test_stray_ack();
        bit bad;
        bad = 1'b0;
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            if (o_tx_valid !== 1'b0 || o_wb_cyc !== 1'b0) bad = 1'b1;
        end
        stray_ack = 1'b0;
        repeat (2) @(negedge i_clk);
        if (o_tx_valid !== 1'b0) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stray_ack: tx_valid=%b cyc=%b required 0/0", o_tx_valid, o_wb_cyc);
        end
        run_frame(8'h52, 32'h0000_0004, 32'h0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [7:0]  exp_b [5];
        logic [7:0]  first;
        logic [7:0]  got;
        int unsigned n;
        exp_b = '{8'h06, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        mem[32'h40]       = 32'hCAFE_F00D;
        model_mem[32'h40] = 32'hCAFE_F00D;
        ack_delay  = 2;
        i_tx_ready = 1'b0;
        send_byte(8'h52);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        n = 0;
        while (!o_tx_valid && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        first = o_tx_data;
        checks++;
        if (o_tx_valid !== 1'b1 || first !== 8'h06) begin
            errors++;
            $display("FAIL bp_first: valid=%b data=%h required 1/06", o_tx_valid, first);
        end
        i_rx_data  = 8'h57;
        i_rx_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            checks++;
            if (o_tx_data !== first || o_tx_valid !== 1'b1 || o_rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: data=%h valid=%b rdy=%b required %h/1/0",
                         c, o_tx_data, o_tx_valid, o_rx_ready, first);
            end
        end
        i_rx_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            recv_byte(got, 1'b1);
            checks++;
            if (got !== exp_b[k]) begin
                errors++;
                $display("FAIL bp_byte[%0d]: got %h required %h", k, got, exp_b[k]);
            end
        end
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_tx_valid !== 1'b0 || o_rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_end: tx_valid=%b rdy=%b required 0/1", o_tx_valid, o_rx_ready);
        end
    endtask

    task automatic test_reset_mid_bus();
        int unsigned n;
        bit          seen_tx;
        ack_en = 1'b0;
        send_byte(8'h52);
        for (int k = 0; k < 4; k++) send_byte(8'h10);
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_wb_cyc !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: cyc=%b required 1", o_wb_cyc);
        end
        #2 i_reset_n = 1'b0;
        #1;
        checks++;
        if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop: cyc=%b stb=%b required 0/0", o_wb_cyc, o_wb_stb);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        ack_en    = 1'b1;
        seen_tx   = 1'b0;
        for (n = 0; n < 30; n++) begin
            @(negedge i_clk);
            if (o_tx_valid !== 1'b0) seen_tx = 1'b1;
        end
        checks++;
        if (seen_tx) begin
            errors++;
            $display("FAIL rst_no_tx: tx_valid seen=1 required 0");
        end
        run_frame(8'h57, 32'h0000_0080, 32'hA5A5_0F0F, 1'b0);
        run_frame(8'h52, 32'h0000_0080, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0]  cmd;
        logic [31:0] addr;
        int unsigned r;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4) cmd = 8'h57;
            else if (r < 8) cmd = 8'h52;
            else begin
                cmd = 8'($urandom);
                if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'hFF;
            end
            addr      = 32'h1000_0000 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            ack_en    = ($urandom_range(0, 7) != 0);
            ack_delay = $urandom_range(0, TO + 2);
            run_frame(cmd, addr, $urandom, $urandom_range(0, 1) == 1);
        end
        ack_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_bad_cmd();
        test_stray_ack();
        test_backpressure();
        test_reset_mid_bus();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_dbg_master.md
WB_DBG_MASTER -- requirements
Module: wb_dbg_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: maximum number of cycles a bus cycle waits for i_wb_ack; legal range 2..65535.
REQ-002 i_clk  input  1  single clock for all logic.
REQ-003 i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_rx_data  input  8  command byte from the UART receiver.
REQ-005 i_rx_valid  input  1  i_rx_data is valid.
REQ-006 o_rx_ready  output  1  block accepts the byte; a transfer occurs when i_rx_valid and o_rx_ready are both high.
REQ-007 o_tx_data  output  8  response byte to the UART transmitter.
REQ-008 o_tx_valid  output  1  o_tx_data is valid.
REQ-009 i_tx_ready  input  1  transmitter accepts the byte; a transfer occurs when o_tx_valid and i_tx_ready are both high.
REQ-010 o_wb_adr  output  32, o_wb_dat  output  32, i_wb_dat  input  32, o_wb_we  output  1, o_wb_sel  output  4, o_wb_stb  output  1, i_wb_ack  input  1, o_wb_cyc  output  1: Wishbone classic initiator, same signal set as the core bus port.

Function
REQ-011 Frame format: command byte, 4 address bytes (LSB first), then for writes 4 data bytes (LSB first).
REQ-012 Command 0x57 ('W') = word write; command 0x52 ('R') = word read; any other command byte produces the single response 0x3F and a return to IDLE.
REQ-013 States: IDLE, ADDR, WDATA, BUS, RESP; IDLE->ADDR on a valid command; ADDR->WDATA (write) or ADDR->BUS (read) after the 4th address byte; WDATA->BUS after the 4th data byte; BUS->RESP on ack or timeout; RESP->IDLE after the last response byte is transferred.
REQ-014 Bytes shift into the address and data registers at bit positions 8*k for byte index k (0..3); a 2-bit counter wraps from 3 to 0.
REQ-015 o_rx_ready is high only in IDLE, ADDR and WDATA; no byte is consumed in BUS or RESP.
REQ-016 In BUS: o_wb_cyc = o_wb_stb = 1, o_wb_sel = 4'hF, o_wb_we = 1 for writes, o_wb_adr = {addr[31:2], 2'b00}; o_wb_dat is valid during writes.
REQ-017 The cycle ends on the first clock edge with i_wb_ack = 1; o_wb_cyc and o_wb_stb deassert in the next cycle; an ack with cyc low is ignored.
REQ-018 For reads, i_wb_dat is captured on the edge on which i_wb_ack is sampled.
REQ-019 A 16-bit timeout counter clears on BUS entry; if TIMEOUT_CYCLES cycles pass without an ack, the cycle is abandoned with cyc/stb low and status = timeout.
REQ-020 Write response: one byte, 0x06 on ack or 0x15 on timeout.
REQ-021 Read response: 0x06 then 4 data bytes (LSB first) on ack; 0x15 only on timeout.
REQ-022 o_tx_data and o_tx_valid stay stable until the byte is transferred; back-pressure on i_tx_ready of any length is tolerated.
REQ-023 A byte transfer and the state transition it causes happen on the same clock edge; a valid frame with no stalls reaches BUS on the edge that accepts its last byte.
REQ-024 There is no inter-byte timeout; a partial frame waits indefinitely.

Reset
REQ-025 On reset assertion, the block forces state IDLE, counters 0, address and data registers 0, o_rx_ready 0 (it rises in the first cycle after reset release), o_tx_valid 0, o_tx_data 0, o_wb_cyc 0, o_wb_stb 0, o_wb_we 0, o_wb_sel 0, o_wb_adr 0, o_wb_dat 0.
REQ-026 Reset during BUS drops cyc/stb immediately and emits no response byte after release.

Structure
REQ-027 The state enum, command codes (0x57, 0x52) and response codes (0x06, 0x15, 0x3F) go in the shared package rv_dbg_pkg.
REQ-028 One sub-module, wb_dbg_timeout, holds the BUS timeout counter and takes clear/enable inputs and a expired output.
REQ-029 The block is a peer initiator; the arbiter between it and the core sits outside this block.

Verification
REQ-030 Write: bytes 57 00 00 00 20 EF BE AD DE, slave acks after 3 cycles -> one bus write, adr 0x20000000, dat 0xDEADBEEF, we=1, sel=F, then response 06.
REQ-031 Read: bytes 52 04 00 00 00, slave returns 0x12345678 -> response 06 78 56 34 12.
REQ-032 Timeout: read of 0xF0000000 with no ack, TIMEOUT_CYCLES=16 -> cyc high for exactly 16 cycles, then response 15.
REQ-033 Bad command: byte 0x41 -> response 3F, no bus cycle; a following valid read completes normally.
REQ-034 Back-pressure: i_tx_ready held low for 10 cycles during a read response -> o_tx_data stable, o_rx_ready low, all 5 bytes delivered in order.
REQ-035 Reset mid-BUS: assert i_reset_n low while cyc=1 -> cyc/stb 0 in the same cycle, no tx byte after release, next frame processed correctly.
